// File: rtl/mac_pkg.sv
// ============================================================================
//  Module      : mac_pkg
//  Description : Shared MAC definitions: rounding-mode codes, default output
//                format widths and the packed output-word layout.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package mac_pkg;

    // Rounding-mode encodings carried on i_rnd_mode (2'b11 aliases RNE)
    localparam logic [1:0] RND_RNE   = 2'b00;
    localparam logic [1:0] RND_TRUNC = 2'b01;
    localparam logic [1:0] RND_HAFZ  = 2'b10;

    // Default output format: 1 sign + 6 exponent + 9 fraction = 16 bits
    localparam int DEF_EXP_W  = 6;
    localparam int DEF_FRAC_W = 9;

    typedef struct packed {
        logic                  sgn;
        logic [DEF_EXP_W-1:0]  exp;
        logic [DEF_FRAC_W-1:0] frac;
    } conv_word_t;

endpackage

`default_nettype wire

// File: rtl/mac_norm_pack_if.sv
// ============================================================================
//  Module      : mac_norm_pack_if
//  Description : Input beat / output beat channels of the normalise-round-pack
//                stage. The slave modport is the stage's view, master the
//                producer/consumer view.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

interface mac_norm_pack_if
    import mac_pkg::*;
#(
    parameter int EXP_W  = DEF_EXP_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int SUM_W  = 13,
    parameter int ADJ_W  = 5,
    parameter int TAG_W  = 5
);
    // Input channel
    logic                    i_valid;
    logic                    o_in_ready;
    logic [EXP_W-1:0]        i_max_exp;
    logic [ADJ_W-1:0]        i_exp_adj;
    logic [SUM_W-1:0]        i_norm_sum;
    logic                    i_sgn;
    logic [1:0]              i_rnd_mode;
    logic                    i_relu;
    logic [TAG_W-1:0]        i_tag;

    // Output channel
    logic                    o_valid;
    logic                    i_ready;
    logic [EXP_W+FRAC_W:0]   o_conv;
    logic [TAG_W-1:0]        o_tag;
    logic                    o_ovf;
    logic                    o_udf;

    modport slave (
        input  i_valid, i_max_exp, i_exp_adj, i_norm_sum, i_sgn,
               i_rnd_mode, i_relu, i_tag, i_ready,
        output o_in_ready, o_valid, o_conv, o_tag, o_ovf, o_udf
    );

    modport master (
        output i_valid, i_max_exp, i_exp_adj, i_norm_sum, i_sgn,
               i_rnd_mode, i_relu, i_tag, i_ready,
        input  o_in_ready, o_valid, o_conv, o_tag, o_ovf, o_udf
    );

endinterface

`default_nettype wire

// File: rtl/fp_round_sat.sv
// ============================================================================
//  Module      : fp_round_sat
//  Description : Combinational first-stage logic: extracts fraction/guard/
//                sticky from the normalised magnitude, rounds, adjusts the
//                exponent and raises overflow/underflow/zero indications.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module fp_round_sat
    import mac_pkg::*;
#(
    parameter int EXP_W  = DEF_EXP_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int SUM_W  = 13,
    parameter int ADJ_W  = 5
)(
    input  wire logic [EXP_W-1:0]  i_max_exp,
    input  wire logic [ADJ_W-1:0]  i_exp_adj,
    input  wire logic [SUM_W-1:0]  i_norm_sum,
    input  wire logic [1:0]        i_rnd_mode,
    output logic      [FRAC_W-1:0] o_frac,
    output logic      [EXP_W-1:0]  o_exp,
    output logic                   o_ovf,
    output logic                   o_udf,
    output logic                   o_zero
);
    // Guard bit position and the sticky field below it (may be empty)
    localparam int               GB     = SUM_W - 2 - FRAC_W;
    localparam int               EW     = EXP_W + 2;
    localparam logic [SUM_W-1:0] S_MASK = {SUM_W{1'b1}} >> (SUM_W - GB);

    logic [FRAC_W-1:0] w_frac;
    logic              w_g;
    logic              w_s;
    logic              w_up;
    logic              w_carry;
    logic [EW-1:0]     w_e;
    logic [EW-1:0]     w_e_rnd;

    // Round the fraction and derive the final biased exponent and flags
    always_comb begin
        w_frac = i_norm_sum[SUM_W-2 -: FRAC_W];
        w_g    = i_norm_sum[GB];
        w_s    = |(i_norm_sum & S_MASK);

        case (i_rnd_mode)
            RND_TRUNC: w_up = 1'b0;
            RND_HAFZ:  w_up = w_g;
            default:   w_up = w_g & (w_s | w_frac[0]);
        endcase

        // An all-ones fraction that rounds up wraps to zero and bumps e
        w_carry = w_up & (&w_frac);
        o_frac  = w_frac + FRAC_W'(w_up);

        // Two's-complement sum at EXP_W+2 bits keeps sign and overflow room
        w_e     = {2'b00, i_max_exp} + {{(EW-ADJ_W){i_exp_adj[ADJ_W-1]}}, i_exp_adj};
        w_e_rnd = w_e + {{(EW-1){1'b0}}, w_carry};
        o_exp   = w_e_rnd[EXP_W-1:0];

        o_zero  = ~|i_norm_sum;
        o_udf   = ~o_zero & (w_e_rnd[EW-1] | (w_e_rnd == '0));
        o_ovf   = ~o_zero & ~w_e_rnd[EW-1] & w_e_rnd[EXP_W];
    end

endmodule

`default_nettype wire

// File: rtl/mac_norm_pack.sv
// ============================================================================
//  Module      : mac_norm_pack
//  Description : Two-stage normalise/round/pack pipeline with valid/ready
//                flow control, tag sideband, saturation/flush, optional ReLU
//                and saturating overflow/underflow event counters.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module mac_norm_pack
    import mac_pkg::*;
#(
    parameter int EXP_W  = DEF_EXP_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int SUM_W  = 13,
    parameter int ADJ_W  = 5,
    parameter int TAG_W  = 5,
    parameter int CNT_W  = 16
)(
    input  wire logic             i_clk,
    input  wire logic             i_rst_n,
    mac_norm_pack_if.slave        bus,
    input  wire logic             i_clr_stats,
    output logic      [CNT_W-1:0] o_ovf_cnt,
    output logic      [CNT_W-1:0] o_udf_cnt
);
    localparam int OUT_W = 1 + EXP_W + FRAC_W;

    // Stage-1 outputs of the rounding logic
    logic [FRAC_W-1:0] w_frac;
    logic [EXP_W-1:0]  w_exp;
    logic              w_ovf;
    logic              w_udf;
    logic              w_zero;

    // Stage-1 register
    logic              s1_valid_q;
    logic [FRAC_W-1:0] s1_frac_q;
    logic [EXP_W-1:0]  s1_exp_q;
    logic              s1_ovf_q;
    logic              s1_udf_q;
    logic              s1_zero_q;
    logic              s1_sgn_q;
    logic              s1_relu_q;
    logic [TAG_W-1:0]  s1_tag_q;

    // Stage-2 (output) register and its next state
    logic              s2_valid_q;
    logic [OUT_W-1:0]  conv_q;
    logic [OUT_W-1:0]  conv_d;
    logic [TAG_W-1:0]  tag_q;
    logic              ovf_q;
    logic              udf_q;

    logic [CNT_W-1:0]  ovf_cnt_q;
    logic [CNT_W-1:0]  ovf_cnt_d;
    logic [CNT_W-1:0]  udf_cnt_q;
    logic [CNT_W-1:0]  udf_cnt_d;

    logic              w_s2_adv;
    logic              w_s1_adv;
    logic              w_s2_load;

    fp_round_sat #(
        .EXP_W  (EXP_W),
        .FRAC_W (FRAC_W),
        .SUM_W  (SUM_W),
        .ADJ_W  (ADJ_W)
    ) u_round (
        .i_max_exp  (bus.i_max_exp),
        .i_exp_adj  (bus.i_exp_adj),
        .i_norm_sum (bus.i_norm_sum),
        .i_rnd_mode (bus.i_rnd_mode),
        .o_frac     (w_frac),
        .o_exp      (w_exp),
        .o_ovf      (w_ovf),
        .o_udf      (w_udf),
        .o_zero     (w_zero)
    );

    // A stage moves when it is empty or its successor moves
    assign w_s2_adv  = ~s2_valid_q | bus.i_ready;
    assign w_s1_adv  = ~s1_valid_q | w_s2_adv;
    assign w_s2_load = w_s2_adv & s1_valid_q;

    assign bus.o_in_ready = w_s1_adv;
    assign bus.o_valid    = s2_valid_q;
    assign bus.o_conv     = conv_q;
    assign bus.o_tag      = tag_q;
    assign bus.o_ovf      = ovf_q;
    assign bus.o_udf      = udf_q;
    assign o_ovf_cnt      = ovf_cnt_q;
    assign o_udf_cnt      = udf_cnt_q;

    // Capture rounded fields and per-beat controls on input transfer
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_q <= 1'b0;
            s1_frac_q  <= '0;
            s1_exp_q   <= '0;
            s1_ovf_q   <= 1'b0;
            s1_udf_q   <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_sgn_q   <= 1'b0;
            s1_relu_q  <= 1'b0;
            s1_tag_q   <= '0;
        end else if (w_s1_adv) begin
            s1_valid_q <= bus.i_valid;
            if (bus.i_valid) begin
                s1_frac_q <= w_frac;
                s1_exp_q  <= w_exp;
                s1_ovf_q  <= w_ovf;
                s1_udf_q  <= w_udf;
                s1_zero_q <= w_zero;
                s1_sgn_q  <= bus.i_sgn;
                s1_relu_q <= bus.i_relu;
                s1_tag_q  <= bus.i_tag;
            end
        end
    end

    // Saturate / flush / ReLU and pack; flags describe the pre-ReLU value
    always_comb begin
        if (s1_zero_q || s1_udf_q) begin
            conv_d = '0;
        end else if (s1_ovf_q) begin
            conv_d = {s1_sgn_q, {EXP_W{1'b1}}, {FRAC_W{1'b1}}};
        end else begin
            conv_d = {s1_sgn_q, s1_exp_q, s1_frac_q};
        end
        if (s1_relu_q && s1_sgn_q) begin
            conv_d = '0;
        end
    end

    // Output register holds while stalled, loads when stage 2 advances
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s2_valid_q <= 1'b0;
            conv_q     <= '0;
            tag_q      <= '0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else if (w_s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                conv_q <= conv_d;
                tag_q  <= s1_tag_q;
                ovf_q  <= s1_ovf_q;
                udf_q  <= s1_udf_q;
            end
        end
    end

    // Saturating event counters; a same-cycle clear wins over an increment
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        udf_cnt_d = udf_cnt_q;
        if (i_clr_stats) begin
            ovf_cnt_d = '0;
            udf_cnt_d = '0;
        end else begin
            if (w_s2_load && s1_ovf_q && !(&ovf_cnt_q)) begin
                ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
            end
            if (w_s2_load && s1_udf_q && !(&udf_cnt_q)) begin
                udf_cnt_d = udf_cnt_q + CNT_W'(1);
            end
        end
    end

    // Counter registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ovf_cnt_q <= '0;
            udf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
            udf_cnt_q <= udf_cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mac_norm_pack.sv
// ============================================================================
//  Module      : tb_mac_norm_pack
//  Description : Self-checking bench for mac_norm_pack: directed scenarios
//                plus randomized streams scored against an arithmetic
//                reference model of the rounding/packing rules.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_mac_norm_pack;
    import mac_pkg::*;

    typedef struct {
        logic [15:0] conv;
        logic [4:0]  tag;
        logic        ovf;
        logic        udf;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic [15:0] ovf_cnt;
    logic [15:0] udf_cnt;

    int checks;
    int errors;
    int exp_ovf;
    int exp_udf;
    beat_t exp_q[$];

    mac_norm_pack_if bif ();

    mac_norm_pack dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .bus         (bif),
        .i_clr_stats (clr),
        .o_ovf_cnt   (ovf_cnt),
        .o_udf_cnt   (udf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: value = 1.m * 2^e with m = top 10 bits, rem = 3 bits below
    function automatic beat_t model(input int me, input int adj, input int ns, input bit sg,
                                    input logic [1:0] rm, input bit rl, input int tg);
        beat_t b;
        int m;
        int rem;
        int e;
        bit up;
        b.tag = 5'(tg);
        b.conv = 16'h0;
        b.ovf = 1'b0;
        b.udf = 1'b0;
        if (ns == 0) return b;
        m   = ns / 8;
        rem = ns % 8;
        e   = me + adj;
        if (rm == RND_TRUNC)     up = 1'b0;
        else if (rm == RND_HAFZ) up = (rem >= 4);
        else                     up = (rem > 4) || (rem == 4 && (m % 2) == 1);
        if (up) m = m + 1;
        if (m == 1024) begin
            m = 512;
            e = e + 1;
        end
        if (e <= 0) begin
            b.udf = 1'b1;
            return b;
        end
        if (e > 63) begin
            b.ovf  = 1'b1;
            b.conv = sg ? 16'hFFFF : 16'h7FFF;
        end else begin
            b.conv = 16'((sg ? 32768 : 0) + e * 512 + (m - 512));
        end
        if (rl && sg) b.conv = 16'h0;
        return b;
    endfunction

    task automatic drive(input int me, input int adj, input int ns, input bit sg,
                         input logic [1:0] rm, input bit rl, input logic [4:0] tg);
        bif.i_max_exp  = 6'(me);
        bif.i_exp_adj  = 5'(adj);
        bif.i_norm_sum = 13'(ns);
        bif.i_sgn      = sg;
        bif.i_rnd_mode = rm;
        bif.i_relu     = rl;
        bif.i_tag      = tg;
    endtask

    // One beat into an idle pipeline, checking 2-cycle latency and the result
    task automatic one_beat(input string nm, input int me, input int adj, input int ns,
                            input bit sg, input logic [1:0] rm, input bit rl,
                            input logic [4:0] tg, input logic [15:0] xconv,
                            input bit xovf, input bit xudf);
        @(negedge clk);
        drive(me, adj, ns, sg, rm, rl, tg);
        bif.i_valid = 1'b1;
        bif.i_ready = 1'b1;
        #1;
        chk({nm, "_in_ready"}, 32'(bif.o_in_ready), 32'd1);
        @(posedge clk);
        #1;
        bif.i_valid = 1'b0;
        chk({nm, "_valid_c1"}, 32'(bif.o_valid), 32'd0);
        @(posedge clk);
        #1;
        chk({nm, "_valid_c2"}, 32'(bif.o_valid), 32'd1);
        chk({nm, "_conv"}, 32'(bif.o_conv), 32'(xconv));
        chk({nm, "_tag"}, 32'(bif.o_tag), 32'(tg));
        chk({nm, "_ovf"}, 32'(bif.o_ovf), 32'(xovf));
        chk({nm, "_udf"}, 32'(bif.o_udf), 32'(xudf));
    endtask

    // Streamed beats scored against the model; bp selects a fixed stall window
    task automatic stream(input string nm, input int nbeats, input bit bp);
        int sent, got, cyc;
        int me, adj, ns;
        bit sg, rl, prev_stall, saw_nrdy;
        logic [1:0] rm;
        beat_t b, hb, held;
        sent = 0; got = 0; cyc = 0;
        prev_stall = 1'b0; saw_nrdy = 1'b0;
        me = 0; adj = 0; ns = 0; sg = 1'b0; rl = 1'b0; rm = 2'b00;
        while (got < nbeats && cyc < 3000) begin
            @(negedge clk);
            if (prev_stall) begin
                chk({nm, "_stall_valid"}, 32'(bif.o_valid), 32'd1);
                chk({nm, "_stall_conv"}, 32'(bif.o_conv), 32'(held.conv));
                chk({nm, "_stall_tag"}, 32'(bif.o_tag), 32'(held.tag));
            end
            if (sent < nbeats && (bp || $urandom_range(0, 3) != 0)) begin
                me  = int'($urandom_range(0, 63));
                adj = int'($urandom_range(0, 31)) - 16;
                ns  = ($urandom_range(0, 15) == 0) ? 0 : int'(32'h1000 | $urandom_range(0, 4095));
                sg  = 1'($urandom_range(0, 1));
                rm  = 2'($urandom_range(0, 3));
                rl  = ($urandom_range(0, 3) == 0);
                drive(me, adj, ns, sg, rm, rl, 5'(sent));
                bif.i_valid = 1'b1;
            end else begin
                bif.i_valid = 1'b0;
            end
            bif.i_ready = bp ? !(cyc >= 4 && cyc < 7) : ($urandom_range(0, 3) != 0);
            #1;
            if (bif.o_valid && bif.i_ready) begin
                if (exp_q.size() == 0) begin
                    chk({nm, "_extra_beat"}, 32'(bif.o_valid), 32'd0);
                end else begin
                    hb = exp_q.pop_front();
                    chk({nm, "_conv"}, 32'(bif.o_conv), 32'(hb.conv));
                    chk({nm, "_tag"}, 32'(bif.o_tag), 32'(hb.tag));
                    chk({nm, "_ovf"}, 32'(bif.o_ovf), 32'(hb.ovf));
                    chk({nm, "_udf"}, 32'(bif.o_udf), 32'(hb.udf));
                end
                got++;
            end
            if (bif.i_valid && bif.o_in_ready) begin
                b = model(me, adj, ns, sg, rm, rl, sent);
                exp_q.push_back(b);
                if (b.ovf) exp_ovf++;
                if (b.udf) exp_udf++;
                sent++;
            end
            prev_stall = bif.o_valid && !bif.i_ready;
            if (prev_stall) begin
                held.conv = bif.o_conv;
                held.tag  = bif.o_tag;
            end
            if (!bif.o_in_ready) saw_nrdy = 1'b1;
            cyc++;
        end
        bif.i_valid = 1'b0;
        bif.i_ready = 1'b1;
        chk({nm, "_beats_out"}, 32'(got), 32'(nbeats));
        chk({nm, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        if (bp) chk({nm, "_in_ready_fell"}, 32'(saw_nrdy), 32'd1);
        chk({nm, "_ovf_cnt"}, 32'(ovf_cnt), 32'(exp_ovf));
        chk({nm, "_udf_cnt"}, 32'(udf_cnt), 32'(exp_udf));
    endtask

    task automatic check_idle_outputs(input string nm);
        chk({nm, "_valid"}, 32'(bif.o_valid), 32'd0);
        chk({nm, "_conv"}, 32'(bif.o_conv), 32'd0);
        chk({nm, "_tag"}, 32'(bif.o_tag), 32'd0);
        chk({nm, "_ovf"}, 32'(bif.o_ovf), 32'd0);
        chk({nm, "_udf"}, 32'(bif.o_udf), 32'd0);
        chk({nm, "_ovf_cnt"}, 32'(ovf_cnt), 32'd0);
        chk({nm, "_udf_cnt"}, 32'(udf_cnt), 32'd0);
    endtask

    initial begin
        checks = 0; errors = 0; exp_ovf = 0; exp_udf = 0;
        rst_n = 1'b0;
        clr   = 1'b0;
        bif.i_valid = 1'b0;
        bif.i_ready = 1'b1;
        drive(0, 0, 0, 1'b0, RND_RNE, 1'b0, 5'd0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic RNE and rounding carry / truncate
        one_beat("rne_basic", 20, 1, 13'b1_000000001_100, 1'b0, RND_RNE, 1'b0, 5'd1, 16'h2A02, 1'b0, 1'b0);
        one_beat("carry_rne", 20, 0, 13'h1FFF, 1'b0, RND_RNE, 1'b0, 5'd2, 16'h2A00, 1'b0, 1'b0);
        one_beat("carry_trunc", 20, 0, 13'h1FFF, 1'b0, RND_TRUNC, 1'b0, 5'd3, 16'h29FF, 1'b0, 1'b0);

        // Overflow saturation, then overflow with ReLU
        one_beat("ovf", 62, 2, 13'h1000, 1'b1, RND_RNE, 1'b0, 5'd4, 16'hFFFF, 1'b1, 1'b0);
        chk("ovf_cnt_1", 32'(ovf_cnt), 32'd1);
        one_beat("ovf_relu", 62, 2, 13'h1000, 1'b1, RND_RNE, 1'b1, 5'd5, 16'h0000, 1'b1, 1'b0);
        chk("ovf_cnt_2", 32'(ovf_cnt), 32'd2);

        // Underflow, zero input, clear racing an underflow
        one_beat("udf", 1, -1, 13'h1234, 1'b0, RND_RNE, 1'b0, 5'd6, 16'h0000, 1'b0, 1'b1);
        chk("udf_cnt_1", 32'(udf_cnt), 32'd1);
        one_beat("zero", 20, 1, 0, 1'b1, RND_HAFZ, 1'b0, 5'd7, 16'h0000, 1'b0, 1'b0);
        chk("zero_udf_cnt", 32'(udf_cnt), 32'd1);
        chk("zero_ovf_cnt", 32'(ovf_cnt), 32'd2);
        clr = 1'b1;
        one_beat("udf_clr", 1, -1, 13'h1001, 1'b0, RND_RNE, 1'b0, 5'd8, 16'h0000, 1'b0, 1'b1);
        @(negedge clk);
        clr = 1'b0;
        #1;
        chk("clr_udf_cnt", 32'(udf_cnt), 32'd0);
        chk("clr_ovf_cnt", 32'(ovf_cnt), 32'd0);
        exp_ovf = 0;
        exp_udf = 0;

        // Randomized stream with random backpressure, then fixed stall window
        stream("rand", 300, 1'b0);
        stream("bp", 8, 1'b1);

        // Reset with two beats in flight
        @(negedge clk);
        bif.i_ready = 1'b0;
        drive(30, 0, 13'h1555, 1'b0, RND_RNE, 1'b0, 5'd9);
        bif.i_valid = 1'b1;
        @(negedge clk);
        drive(31, 0, 13'h1AAA, 1'b1, RND_RNE, 1'b0, 5'd10);
        @(negedge clk);
        bif.i_valid = 1'b0;
        chk("inflight_valid", 32'(bif.o_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midreset");
        exp_ovf = 0;
        exp_udf = 0;
        @(negedge clk);
        rst_n = 1'b1;
        bif.i_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("post_reset_valid", 32'(bif.o_valid), 32'd0);
        end
        one_beat("post_reset_rne", 20, 1, 13'b1_000000001_100, 1'b0, RND_RNE, 1'b0, 5'd11, 16'h2A02, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mac_norm_pack.md
# mac_norm_pack

Parametrised final normalise/round/pack stage of the MAC pipeline. It takes the pre-normalised accumulator magnitude, sign and exponent terms from the preceding MAC stage and produces a packed floating-point result. Beyond the previous fixed 16-bit stage, it adds:
- selectable rounding,
- overflow saturation and underflow flush with statistics counters,
- an optional ReLU,
- a valid/ready handshake in place of the global inhibit,
- a tag sideband that travels in lock-step with data.

## Interface
Parameters:
- EXP_W, 6, output exponent width
- FRAC_W, 9, output fraction width; output width = 1+EXP_W+FRAC_W
- SUM_W, 13, i_norm_sum width, ≥ FRAC_W+2
- ADJ_W, 5, signed exponent-adjust width
- TAG_W, 5, sideband width
- CNT_W, 16, statistics counter width

Ports (clock and reset: reset i_rst_n, asynchronous, active-low; clock i_clk):
- i_clk  in  1  clock
- i_rst_n  in  1  async active-low reset
- i_valid  in  1  input beat valid
- o_in_ready  out  1  stage can accept a beat
- i_max_exp  in  EXP_W  block max exponent (unsigned, biased)
- i_exp_adj  in  ADJ_W  signed adjust (carry minus leading-zero count)
- i_norm_sum  in  SUM_W  magnitude, leading one at bit SUM_W-1 or all zero
- i_sgn  in  1  result sign
- i_rnd_mode  in  2  00 RNE, 01 truncate, 10 half-away-from-zero, 11 = RNE
- i_relu  in  1  clamp negative results to +0
- i_tag  in  TAG_W  sideband, returned unmodified
- o_valid  out  1  output beat valid
- i_ready  in  1  downstream accepts
- o_conv  out  1+EXP_W+FRAC_W  {sign, exp, frac}
- o_tag  out  TAG_W  sideband aligned with o_conv
- o_ovf, o_udf  out  1  per-beat flags aligned with o_conv
- i_clr_stats  in  1  synchronous clear of counters
- o_ovf_cnt, o_udf_cnt  out  CNT_W  saturating event counters

## Operation
- **Field extraction.** frac = i_norm_sum[SUM_W-2 -: FRAC_W]. G = the next bit below frac. S = OR of the remaining lower bits.
- **Exponent.** e = i_max_exp + sign-extended i_exp_adj, computed at EXP_W+2 bits signed.
- **Round-up decision:**
  - RNE: G & (S | frac[0])
  - truncate: 0
  - half-away: G
- **Rounding overflow.** If frac is all ones and rounds up, frac becomes 0 and e becomes e+1.
- **Zero input.** i_norm_sum == 0 gives a +0 result (all bits zero). No flags are raised.
- **Underflow.** e ≤ 0 gives +0 and o_udf=1.
- **Overflow.** e > 2^EXP_W-1 gives {sgn, all-ones exp, all-ones frac} and o_ovf=1. The format has no infinity.
- **ReLU.** If i_relu=1 and i_sgn=1 with a nonzero result, output is +0. The overflow/underflow flags still reflect the pre-ReLU value.
- **Counters.**
  - Each counter increments by 1 when its flag is set on a beat loaded into the output register.
  - Counters saturate at 2^CNT_W-1.
  - i_clr_stats has priority over a same-cycle increment; that event is dropped.

## Timing
- **Pipeline.** Two registered stages.
  - S1: exponent computation, rounding and flags.
  - S2: saturate/flush/ReLU/pack into the output register.
- **Latency.** 2 cycles from input acceptance to o_valid when there is no stall.
- **Handshakes.**
  - Input transfer occurs on i_valid & o_in_ready.
  - Output transfer occurs on o_valid & i_ready.
  - Each stage advances when it is empty or when its successor advances.
  - o_in_ready = ~S1_valid | S2_advance. This is combinational from i_ready, with full throughput of 1 beat/cycle.
- **Stall.** While o_valid=1 and i_ready=0, o_conv/o_tag/o_ovf/o_udf hold stable. No beat is lost, duplicated or reordered.
- **Per-beat controls.** i_rnd_mode and i_relu are sampled with each beat, so mixed modes within a stream are legal.
- **Reset values.** Every output is 0 after reset. The valid bits are cleared.
- **Reset mid-stream.** Any beats in flight are discarded. o_valid=0 in the first cycle after reset release.

## Structure
- Shared package mac_pkg holds:
  - rounding-mode constants (RND_RNE, RND_TRUNC, RND_HAFZ)
  - default EXP_W/FRAC_W
  - a packed output-word typedef
- Sub-module fp_round_sat holds the combinational S1 logic: fields → rounded frac, adjusted e, ovf/udf. The pipeline/handshake wrapper and counters live in the top module.

## Test plan
All scenarios use default parameters.
- **Basic RNE.** max_exp=20, adj=+1, norm_sum=13'b1_000000001_100, sgn=0, RNE → o_conv=16'h2A02 two cycles later, no flags.
- **Rounding carry.** norm_sum=13'h1FFF, max_exp=20, adj=0, RNE → 16'h2A00. Same input with truncate → 16'h29FF.
- **Overflow.** max_exp=62, adj=+2, sgn=1 → 16'hFFFF, o_ovf=1, o_ovf_cnt=1. A second beat with i_relu=1 → 16'h0000 with o_ovf=1, o_ovf_cnt=2.
- **Underflow and zero.** max_exp=1, adj=-1 → 16'h0000, o_udf=1, o_udf_cnt=1. norm_sum=0 → 16'h0000 with no flags. i_clr_stats together with another underflow → counter reads 0.
- **Backpressure.** Stream 8 beats with tags 0..7 while i_ready is low for 3 cycles mid-stream. o_in_ready falls, outputs stay stable, and tags 0..7 emerge in order exactly once.
- **Reset mid-stream.** Assert i_rst_n low with 2 beats in flight → all outputs 0 and counters 0. After release, o_valid stays 0 until new input arrives.
